fsm_clock_sequencer: RTL and testbench
======================================

# fsm_clock_sequencer

Generates the per-FSM execution enable ("tick") for the four PIO state machines from programmable fractional clock dividers, and owns their run/stop and synchronized divider-restart control. It sits between the register interface and the four FSMs. The FSMs advance one instruction only on their tick, so it paces every FSM output and drive value that reaches the per-pin output arbitration.

## Interface
Parameters:
- NUM_FSM, 4: number of state machines.
- DIV_INT_W, 16: integer divider width.
- DIV_FRAC_W, 8: fractional divider width.

Ports:
- clk  in  1  the single block clock.
- rst  in  1  reset, asynchronous, active-high.
- cfg_wr  in  1  one-cycle divider write strobe.
- cfg_sel  in  2  FSM index targeted by cfg_wr.
- cfg_int  in  DIV_INT_W  integer part of the divider.
- cfg_frac  in  DIV_FRAC_W  fractional part, in 1/256 units.
- enable_set  in  NUM_FSM  per-FSM run request, level sampled each cycle.
- enable_clr  in  NUM_FSM  per-FSM stop request.
- restart  in  NUM_FSM  per-FSM divider restart mask, one-cycle pulse.
- fsm_enabled  out  NUM_FSM  registered run state.
- fsm_tick  out  NUM_FSM  registered one-cycle execute enable per FSM.

## Operation
- Per FSM, the block holds the following state:
  - en flag;
  - int_r and frac_r divider registers;
  - down-counter cnt, DIV_INT_W bits;
  - fractional accumulator acc, DIV_FRAC_W bits.
- Divider value is D = int_r + frac_r/256.
  - int_r == 0 means 65536, and frac_r is then ignored.
  - D = 1.0 produces a tick every cycle.
- Tick generation for an enabled FSM:
  - fsm_tick[i] = 1 in the cycle where cnt == 0.
  - In that same cycle: {carry, acc} <= acc + frac_r, and cnt <= int_r - 1 + carry, using the 65536 rule when int_r == 0.
  - Otherwise cnt decrements.
  - Long-run tick rate is exactly 1/D. Individual periods are floor(D) or floor(D)+1.
- Run control:
  - Set: enable_set[i] with en = 0 sets en, clears cnt and acc.
  - Set while already running: enable_set[i] with en = 1 has no effect and does not restart the divider.
  - Clear: enable_clr[i] clears en, and overrides enable_set[i] in the same cycle.
  - While disabled: fsm_tick[i] = 0, and cnt/acc hold their values.
- Restart:
  - restart[i] clears cnt and acc for every set bit in the same cycle. Multiple FSMs restarted together tick in lockstep when their dividers are equal.
  - restart together with enable_set: the FSM starts, with the same effect as the set alone.
  - restart together with enable_clr: the FSM is disabled with cnt and acc cleared.
- Divider writes:
  - cfg_wr updates int_r/frac_r of FSM cfg_sel at the next edge.
  - The running countdown is not disturbed; the new value applies from the next reload.
- Reset values:
  - en = 0, int_r = 1, frac_r = 0, cnt = 0, acc = 0.
  - fsm_enabled = 0, fsm_tick = 0.

## Timing
- fsm_enabled[i] rises the cycle after enable_set[i] is sampled.
  - Enable sampled at edge N: fsm_enabled = 1 and first fsm_tick both appear after edge N+1.
  - Subsequent ticks follow at the divider periods.
- enable_clr sampled at edge N: fsm_enabled and fsm_tick are both 0 from edge N+1. No trailing tick.
- restart sampled at edge N on an enabled FSM: tick after edge N+1, then periodic.
- Reset asserted mid-operation: all outputs go to 0 immediately (asynchronous). The first cycle after deassertion behaves as post-reset idle.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- The shared package fsm_pkg holds NUM_FSM, DIV_INT_W, DIV_FRAC_W, and the divider-reset constants DIV_INT_RST = 1 and DIV_FRAC_RST = 0. The output arbitrator and the FSM cores use the same package.
- One sub-module, fsm_clock_divider, holds one FSM's en, int_r, frac_r, cnt, acc and tick logic. The top instantiates it NUM_FSM times and decodes cfg_sel into per-instance write enables.

## Test plan
- Reset then enable_set = 4'b0001 at cycle 10: fsm_enabled[0] = 1 from cycle 11, fsm_tick[0] = 1 every cycle, all other bits stay 0.
- FSM1 with int = 3, frac = 128 (D = 3.5), enabled: tick intervals alternate 3, 4, 3, 4, with exactly 8 ticks in 28 cycles.
- FSM2 with int = 0: ticks spaced 65536 cycles apart, and a frac write has no effect on the spacing.
- FSM0 with D = 5 and FSM3 with D = 5, enabled 2 cycles apart, then restart = 4'b1001: both tick the next cycle and coincide on every tick after.
- enable_set[1] and enable_clr[1] in the same cycle: fsm_enabled[1] stays 0 and no tick is produced.
- cfg_wr changes FSM0 from int = 4 to int = 2 mid-countdown: the current period completes at 4 and later periods are 2. Asserting rst mid-run zeroes fsm_tick and fsm_enabled in the same cycle.

Source files
------------

// File: rtl/fsm_pkg.sv
// +----------------------------------------------------------------------------+
// | fsm_pkg: shared widths and divider reset values for the PIO FSM cluster.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package fsm_pkg;

  localparam int NUM_FSM    = 4;
  localparam int DIV_INT_W  = 16;
  localparam int DIV_FRAC_W = 8;

  localparam logic [DIV_INT_W-1:0]  DIV_INT_RST  = 16'd1;
  localparam logic [DIV_FRAC_W-1:0] DIV_FRAC_RST = 8'd0;

  typedef logic [NUM_FSM-1:0] fsm_mask_t;

endpackage

`default_nettype wire

// File: rtl/fsm_clock_divider.sv
// +----------------------------------------------------------------------------+
// | fsm_clock_divider: fractional divider and run control for one FSM.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fsm_clock_divider
  import fsm_pkg::*;
#(
  parameter int INT_W  = DIV_INT_W,
  parameter int FRAC_W = DIV_FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr_i,
  input  logic [INT_W-1:0]  cfg_int_i,
  input  logic [FRAC_W-1:0] cfg_frac_i,
  input  logic              enable_set_i,
  input  logic              enable_clr_i,
  input  logic              restart_i,
  output logic              enabled_o,
  output logic              tick_o
);

  logic              en_q, en_d;
  logic [INT_W-1:0]  int_q, int_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [INT_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              enabled_q;
  logic              tick_q;

  logic              w_fire;
  logic              w_start;
  logic [FRAC_W-1:0] w_frac_eff;
  logic [FRAC_W:0]   w_acc_sum;

  always_comb begin
    w_fire     = en_q && (cnt_q == '0);
    w_start    = enable_set_i && !en_q && !enable_clr_i;
    // An integer part of zero encodes the maximum count; the fraction is ignored there.
    w_frac_eff = (int_q == '0) ? '0 : frac_q;
    w_acc_sum  = {1'b0, acc_q} + {1'b0, w_frac_eff};

    en_d   = en_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    int_d  = int_q;
    frac_d = frac_q;

    if (w_fire) begin
      acc_d = w_acc_sum[FRAC_W-1:0];
      cnt_d = int_q - INT_W'(1) + INT_W'(w_acc_sum[FRAC_W]);
    end else if (en_q) begin
      cnt_d = cnt_q - INT_W'(1);
    end

    if (enable_clr_i) begin
      en_d = 1'b0;
    end else if (w_start) begin
      en_d = 1'b1;
    end

    if (restart_i || w_start) begin
      cnt_d = '0;
      acc_d = '0;
    end

    if (cfg_wr_i) begin
      int_d  = cfg_int_i;
      frac_d = cfg_frac_i;
    end
  end

  // Outputs are one stage behind the run state so the first tick and the
  // enabled flag become visible together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q      <= 1'b0;
      int_q     <= INT_W'(DIV_INT_RST);
      frac_q    <= FRAC_W'(DIV_FRAC_RST);
      cnt_q     <= '0;
      acc_q     <= '0;
      enabled_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      en_q      <= en_d;
      int_q     <= int_d;
      frac_q    <= frac_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      enabled_q <= en_q;
      tick_q    <= w_fire;
    end
  end

  assign enabled_o = enabled_q;
  assign tick_o    = tick_q;

endmodule

`default_nettype wire

// File: rtl/fsm_clock_sequencer.sv
// +----------------------------------------------------------------------------+
// | fsm_clock_sequencer: per-FSM execute ticks from fractional dividers.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module fsm_clock_sequencer #(
  parameter int NUM_FSM    = fsm_pkg::NUM_FSM,
  parameter int DIV_INT_W  = fsm_pkg::DIV_INT_W,
  parameter int DIV_FRAC_W = fsm_pkg::DIV_FRAC_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_wr,
  input  logic [$clog2(NUM_FSM)-1:0] cfg_sel,
  input  logic [DIV_INT_W-1:0]       cfg_int,
  input  logic [DIV_FRAC_W-1:0]      cfg_frac,
  input  logic [NUM_FSM-1:0]         enable_set,
  input  logic [NUM_FSM-1:0]         enable_clr,
  input  logic [NUM_FSM-1:0]         restart,
  output logic [NUM_FSM-1:0]         fsm_enabled,
  output logic [NUM_FSM-1:0]         fsm_tick
);

  localparam int SEL_W = $clog2(NUM_FSM);

  logic [NUM_FSM-1:0] w_wr_sel;

  for (genvar i = 0; i < NUM_FSM; i++) begin : g_fsm
    assign w_wr_sel[i] = cfg_wr && (cfg_sel == SEL_W'(i));

    fsm_clock_divider #(
      .INT_W  (DIV_INT_W),
      .FRAC_W (DIV_FRAC_W)
    ) u_div (
      .clk          (clk),
      .rst          (rst),
      .cfg_wr_i     (w_wr_sel[i]),
      .cfg_int_i    (cfg_int),
      .cfg_frac_i   (cfg_frac),
      .enable_set_i (enable_set[i]),
      .enable_clr_i (enable_clr[i]),
      .restart_i    (restart[i]),
      .enabled_o    (fsm_enabled[i]),
      .tick_o       (fsm_tick[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_fsm_clock_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_fsm_clock_sequencer: directed scenarios plus randomized model check.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fsm_clock_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_wr;
  logic [1:0] cfg_sel;
  logic [15:0] cfg_int;
  logic [7:0] cfg_frac;
  logic [3:0] enable_set;
  logic [3:0] enable_clr;
  logic [3:0] restart;
  logic [3:0] fsm_enabled;
  logic [3:0] fsm_tick;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fsm_clock_sequencer #(
    .NUM_FSM    (4),
    .DIV_INT_W  (16),
    .DIV_FRAC_W (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_wr      (cfg_wr),
    .cfg_sel     (cfg_sel),
    .cfg_int     (cfg_int),
    .cfg_frac    (cfg_frac),
    .enable_set  (enable_set),
    .enable_clr  (enable_clr),
    .restart     (restart),
    .fsm_enabled (fsm_enabled),
    .fsm_tick    (fsm_tick)
  );

  // Tick k of a run lands floor(k*D) cycles after the first, D in 1/256 units.
  function automatic bit is_tick(input longint off, input longint d256);
    longint k;
    if (off < 0) return 1'b0;
    k = (off * 256 + d256 - 1) / d256;
    return ((k * d256) / 256) == off;
  endfunction

  task automatic drive_idle();
    cfg_wr = 1'b0; cfg_sel = '0; cfg_int = '0; cfg_frac = '0;
    enable_set = '0; enable_clr = '0; restart = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_div(input int sel, input int iv, input int fv);
    @(negedge clk);
    cfg_wr = 1'b1; cfg_sel = 2'(sel); cfg_int = 16'(iv); cfg_frac = 8'(fv);
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic pulse_enable(input logic [3:0] m);
    enable_set = m;
    @(negedge clk);
    enable_set = '0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (fsm_enabled !== 4'b0000) begin
        failures++; $display("FAIL reset_enabled: got %b expected 0000", fsm_enabled);
      end
      checks++;
      if (fsm_tick !== 4'b0000) begin
        failures++; $display("FAIL reset_tick: got %b expected 0000", fsm_tick);
      end
    end
  endtask

  task automatic test_single_enable();
    do_reset();
    repeat (8) @(negedge clk);
    pulse_enable(4'b0001);
    checks++;
    if (fsm_enabled !== 4'b0000) begin
      failures++; $display("FAIL single_en_latency: got %b expected 0000", fsm_enabled);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (fsm_enabled !== 4'b0001) begin
        failures++; $display("FAIL single_enabled c=%0d: got %b expected 0001", c, fsm_enabled);
      end
      checks++;
      if (fsm_tick !== 4'b0001) begin
        failures++; $display("FAIL single_tick c=%0d: got %b expected 0001", c, fsm_tick);
      end
    end
  endtask

  task automatic test_frac_divider();
    int ticks[$];
    int in_window;
    bit other_bad;
    do_reset();
    write_div(1, 3, 128);
    pulse_enable(4'b0010);
    other_bad = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (fsm_tick[1] === 1'b1) ticks.push_back(c);
      if ({fsm_tick[3:2], fsm_tick[0]} !== 3'b000) other_bad = 1'b1;
    end
    checks++;
    if (ticks.size() < 9) begin
      failures++; $display("FAIL frac_count: got %0d ticks expected at least 9", ticks.size());
    end else begin
      checks++;
      if (ticks[0] != 0) begin
        failures++; $display("FAIL frac_first: got cycle %0d expected 0", ticks[0]);
      end
      for (int j = 0; j < 8; j++) begin
        checks++;
        if (ticks[j+1] - ticks[j] != ((j % 2 == 0) ? 3 : 4)) begin
          failures++;
          $display("FAIL frac_interval j=%0d: got %0d expected %0d", j, ticks[j+1] - ticks[j], (j % 2 == 0) ? 3 : 4);
        end
      end
      in_window = 0;
      foreach (ticks[j]) if (ticks[j] >= ticks[0] && ticks[j] < ticks[0] + 28) in_window++;
      checks++;
      if (in_window != 8) begin
        failures++; $display("FAIL frac_window: got %0d ticks in 28 cycles expected 8", in_window);
      end
    end
    checks++;
    if (other_bad) begin
      failures++; $display("FAIL frac_others: got stray tick on other FSM expected none");
    end
  endtask

  task automatic test_int_zero();
    int ticks[$];
    do_reset();
    write_div(2, 0, 200);
    pulse_enable(4'b0100);
    for (int c = 0; c < 65540; c++) begin
      @(negedge clk);
      if (fsm_tick[2] === 1'b1) ticks.push_back(c);
    end
    checks++;
    if (ticks.size() != 2) begin
      failures++; $display("FAIL int0_count: got %0d ticks expected 2", ticks.size());
    end else begin
      checks++;
      if (ticks[0] != 0 || ticks[1] != 65536) begin
        failures++; $display("FAIL int0_spacing: got %0d,%0d expected 0,65536", ticks[0], ticks[1]);
      end
    end
  endtask

  task automatic test_restart_lockstep();
    do_reset();
    write_div(0, 5, 0);
    write_div(3, 5, 0);
    pulse_enable(4'b0001);
    @(negedge clk);
    pulse_enable(4'b1000);
    repeat (3) @(negedge clk);
    restart = 4'b1001;
    @(negedge clk);
    restart = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (fsm_tick[0] !== (c % 5 == 0)) begin
        failures++; $display("FAIL restart_fsm0 c=%0d: got %b expected %b", c, fsm_tick[0], (c % 5 == 0));
      end
      checks++;
      if (fsm_tick[3] !== (c % 5 == 0)) begin
        failures++; $display("FAIL restart_fsm3 c=%0d: got %b expected %b", c, fsm_tick[3], (c % 5 == 0));
      end
    end
  endtask

  task automatic test_set_clr_same();
    do_reset();
    enable_set = 4'b0010;
    enable_clr = 4'b0010;
    @(negedge clk);
    drive_idle();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (fsm_enabled !== 4'b0000 || fsm_tick !== 4'b0000) begin
        failures++;
        $display("FAIL set_clr c=%0d: got en=%b tick=%b expected en=0000 tick=0000", c, fsm_enabled, fsm_tick);
      end
    end
  endtask

  task automatic test_cfg_midrun_and_reset();
    bit exp;
    do_reset();
    write_div(0, 4, 0);
    pulse_enable(4'b0001);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      exp = (c == 0) || (c == 4) || (c == 6) || (c == 8) || (c == 10);
      checks++;
      if (fsm_tick[0] !== exp) begin
        failures++; $display("FAIL cfg_midrun c=%0d: got %b expected %b", c, fsm_tick[0], exp);
      end
      if (c == 1) begin
        cfg_wr = 1'b1; cfg_sel = 2'd0; cfg_int = 16'd2; cfg_frac = 8'd0;
      end else begin
        cfg_wr = 1'b0;
      end
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (fsm_enabled !== 4'b0000 || fsm_tick !== 4'b0000) begin
      failures++;
      $display("FAIL async_reset: got en=%b tick=%b expected en=0000 tick=0000", fsm_enabled, fsm_tick);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (fsm_enabled !== 4'b0000 || fsm_tick !== 4'b0000) begin
      failures++;
      $display("FAIL post_reset_idle: got en=%b tick=%b expected en=0000 tick=0000", fsm_enabled, fsm_tick);
    end
  endtask

  task automatic test_random();
    bit         en_st [4];
    longint     base_e[4];
    longint     dval  [4];
    logic [3:0] exp_en;
    logic [3:0] exp_tick;
    int         sel;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      en_st[i] = 1'b0; base_e[i] = 0; dval[i] = 256;
    end
    exp_en = '0;
    exp_tick = '0;
    for (int e = 1; e <= 2000; e++) begin
      @(negedge clk);
      checks++;
      if (fsm_tick !== exp_tick) begin
        failures++; $display("FAIL rand_tick edge=%0d: got %b expected %b", e, fsm_tick, exp_tick);
      end
      checks++;
      if (fsm_enabled !== exp_en) begin
        failures++; $display("FAIL rand_enabled edge=%0d: got %b expected %b", e, fsm_enabled, exp_en);
      end

      drive_idle();
      for (int i = 0; i < 4; i++) begin
        enable_set[i] = ($urandom_range(0, 5) == 0);
        enable_clr[i] = ($urandom_range(0, 19) == 0);
        restart[i]    = ($urandom_range(0, 11) == 0);
      end
      sel = $urandom_range(0, 3);
      if (!en_st[sel] && $urandom_range(0, 3) == 0) begin
        cfg_wr   = 1'b1;
        cfg_sel  = 2'(sel);
        cfg_int  = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom_range(1, 4));
        cfg_frac = 8'($urandom_range(0, 255));
      end

      for (int i = 0; i < 4; i++) begin
        exp_en[i]   = en_st[i];
        exp_tick[i] = en_st[i] && is_tick(longint'(e) - base_e[i] - 1, dval[i]);
      end

      for (int i = 0; i < 4; i++) begin
        if (enable_clr[i]) begin
          en_st[i] = 1'b0;
        end else if (enable_set[i] && !en_st[i]) begin
          en_st[i] = 1'b1;
          base_e[i] = e;
        end else if (restart[i] && en_st[i]) begin
          base_e[i] = e;
        end
      end
      if (cfg_wr) begin
        dval[sel] = (cfg_int == 16'd0) ? 64'd16777216 : (longint'(cfg_int) * 256 + longint'(cfg_frac));
      end
    end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    drive_idle();
    rst = 1'b1;
    test_reset();
    test_single_enable();
    test_frac_divider();
    test_restart_lockstep();
    test_set_clr_same();
    test_cfg_midrun_and_reset();
    test_random();
    test_int_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
